subreg_tim_div_mc: RTL and testbench
====================================

Name: subreg_tim_div_mc

Overview:
Multi-channel successor of the single sub-regulation timing divider.
- Each of C_CH channels emits exactly PULSE_N clock-enable pulses per PERIOD cycles, spread as evenly as possible (low jitter versus PWM).
- Adds double-buffered, glitch-free reconfiguration at period boundaries, per-channel run control, a global phase sync, and boundary/pending status.
- Sits between the register/bus interface and the LED/key scan, baud and tick consumers.

Parameters:
C_CH, 4, number of independent channels (1..16)
C_PERIOD_W, 16, width of PERIOD and PULSE_N values

Ports:
CK_i  in  1  system clock
XARST_i  in  1  reset, asynchronous, active-low
WR_i  in  1  one-cycle config write strobe
WR_CH_i  in  max(1,clog2(C_CH))  target channel of write
WR_SEL_i  in  1  0 = PERIOD shadow, 1 = PULSE_N shadow
WR_DAT_i  in  C_PERIOD_W  write data
RUN_i  in  C_CH  per-channel run enable (level)
SYNC_i  in  1  one-cycle pulse: restart all running channels at phase 0
EN_CK_o  out  C_CH  per-channel enable pulse
WRAP_o  out  C_CH  high on last cycle of each period
PEND_o  out  C_CH  shadow differs from active / commit pending

Behaviour:
- Per-channel state:
  - shadow PER_S and PN_S
  - active PER_A and PN_A
  - signed accumulator ACC (C_PERIOD_W+1 bits)
  - phase counter PH (C_PERIOD_W bits)
  - pending flag
- Reset: all of the above = 0. EN_CK_o = WRAP_o = PEND_o = 0. Channels idle until configured.
- Write: WR_i with WR_CH_i >= C_CH is ignored. Otherwise it loads the selected shadow and sets pending.
- Effective pulse count: N = min(PN_A, PER_A); excess saturates.
- Channel active when RUN_i[c]=1 and PER_A != 0.
- When active, each clock:
  - ACC <= ACC - N + (EN ? PER_A : 0), computed in C_PERIOD_W+2 bits, result fits C_PERIOD_W+1.
  - EN = ACC sign bit.
  - EN_CK_o[c] = active & ACC[MSB]. Combinational from registers, zero latency.
  - PH increments and wraps to 0 after PER_A-1.
  - WRAP_o[c] = active & (PH == PER_A-1).
- Guarantees for N < PER_A:
  - ACC returns to 0 at every boundary.
  - Exactly N pulses per period.
  - First cycle after activation has EN=0.
- N == PER_A: EN=0 on first cycle, then continuously 1.
- Commit (active <= shadow, ACC <= 0, PH <= 0, pending <= 0) occurs when any of these holds:
  - on a WRAP cycle with pending set;
  - every cycle while the channel is inactive;
  - on SYNC_i.
- SYNC_i: ACC <= 0 and PH <= 0 on all channels, with pending shadows committed. Takes priority over the boundary. Next cycle is phase 0.
- Write in the same cycle as a commit: the new WR_DAT_i value is the committed value (write-through). Pending ends 0.
- RUN_i falling: next cycle ACC = PH = 0, EN = 0.
- RUN_i rising: restarts from phase 0.
- PER_A written to 0 while running: commits at the next boundary, then the channel goes idle.
- PEND_o[c] = pending flag, registered.
- XARST_i asserted mid-operation: all state cleared immediately and asynchronously. Outputs go low in the same instant.

Decomposition:
- Shared package subreg_tim_pkg:
  - constants C_SEL_PERIOD=0, C_SEL_PULSE_N=1
  - clog2 function
  - channel-index width function
- One sub-module, subreg_tim_div_ch:
  - single channel with shadow/active registers, ACC, PH and commit logic
  - instantiated C_CH times by generate
- Top level does write-address decode and SYNC fan-out only.

Test Plan:
- Reset, write ch0 PERIOD=7, PULSE_N=3, RUN_i[0]=1 -> EN_CK_o[0] per cycle 0,1,0,1,0,1,0 repeating. WRAP_o[0] on cycle 6, 13, ... 3 pulses per 7 cycles.
- ch1 PERIOD=3, PULSE_N=2 concurrently with ch0 -> ch1 pattern 0,1,1 repeating. ch0 unaffected.
- ch0 running 7/3, write PULSE_N=5 mid-period -> PEND_o[0]=1 until the WRAP cycle. Old pattern is completed. From the next cycle, 5 pulses per 7. PEND_o[0]=0.
- PULSE_N=9 with PERIOD=7 -> saturates to N=7: EN 0 then constantly 1. PULSE_N=0 -> EN never high, WRAP still every 7.
- SYNC_i pulse at phase 4 on channels with different periods -> all PH=0 next cycle, patterns restart from cycle 0. SYNC coincident with a write commits the written value.
- Assert XARST_i at phase 3, release after 2 cycles -> all outputs 0 and PEND_o=0. Channels idle until rewritten, since active PERIOD=0.

Source files
------------

// File: rtl/subreg_tim_div_mc_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel
// sub-regulation timing divider.
package subreg_tim_pkg;

  localparam logic C_SEL_PERIOD  = 1'b0;
  localparam logic C_SEL_PULSE_N = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Channel-select width; a single channel still needs a 1-bit port.
  function automatic int ch_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/subreg_tim_div_ch.sv
// One divider channel: double-buffered PERIOD/PULSE_N, error accumulator
// spreading N pulses over PERIOD cycles, phase counter and commit control.
module subreg_tim_div_ch
  import subreg_tim_pkg::*;
#(
  parameter int C_PERIOD_W = 16
) (
  input  logic                  CK_i,
  input  logic                  XARST_i,
  input  logic                  wr,
  input  logic                  wr_sel,
  input  logic [C_PERIOD_W-1:0] wr_dat,
  input  logic                  run,
  input  logic                  sync,
  output logic                  en_ck,
  output logic                  wrap,
  output logic                  pend
);

  localparam int W = C_PERIOD_W;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] per_s, pn_s, per_a, pn_a, ph;
  logic [W-1:0] per_nxt, pn_nxt, n_eff;
  logic [W:0]   acc, acc_nxt;
  logic         pend_q, active, commit;

  assign active = run & (per_a != '0);
  assign n_eff  = (pn_a > per_a) ? per_a : pn_a;
  assign en_ck  = active & acc[W];
  assign wrap   = active & (ph == per_a - ONE);
  assign pend   = pend_q;

  // Any commit is a full restart; while idle this keeps active == shadow.
  assign commit = sync | ~active | (wrap & pend_q);

  // Write data flows through to the active copy when it lands on a commit.
  assign per_nxt = (wr && wr_sel == C_SEL_PERIOD)  ? wr_dat : per_s;
  assign pn_nxt  = (wr && wr_sel == C_SEL_PULSE_N) ? wr_dat : pn_s;

  // Accumulator stays within [-N, PER) so W+1 bits of wrap-around
  // arithmetic give the exact result.
  assign acc_nxt = acc - {1'b0, n_eff} + (en_ck ? {1'b0, per_a} : '0);

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      per_s  <= '0;
      pn_s   <= '0;
      per_a  <= '0;
      pn_a   <= '0;
      acc    <= '0;
      ph     <= '0;
      pend_q <= 1'b0;
    end else begin
      per_s <= per_nxt;
      pn_s  <= pn_nxt;
      if (commit) begin
        per_a  <= per_nxt;
        pn_a   <= pn_nxt;
        acc    <= '0;
        ph     <= '0;
        pend_q <= 1'b0;
      end else begin
        acc <= acc_nxt;
        ph  <= wrap ? '0 : ph + ONE;
        if (wr) pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/subreg_tim_div_mc.sv
// Multi-channel evenly-spread clock-enable divider: decodes config writes
// to the channel array and fans out the global phase sync.
module subreg_tim_div_mc
  import subreg_tim_pkg::*;
#(
  parameter  int C_CH       = 4,
  parameter  int C_PERIOD_W = 16,
  localparam int C_CH_W     = ch_w(C_CH)
) (
  input  logic                  CK_i,
  input  logic                  XARST_i,
  input  logic                  WR_i,
  input  logic [C_CH_W-1:0]     WR_CH_i,
  input  logic                  WR_SEL_i,
  input  logic [C_PERIOD_W-1:0] WR_DAT_i,
  input  logic [C_CH-1:0]       RUN_i,
  input  logic                  SYNC_i,
  output logic [C_CH-1:0]       EN_CK_o,
  output logic [C_CH-1:0]       WRAP_o,
  output logic [C_CH-1:0]       PEND_o
);

  // Addresses at or beyond C_CH match no channel, so those writes vanish.
  for (genvar c = 0; c < C_CH; c++) begin : g_ch
    logic wr_c;
    assign wr_c = WR_i & (WR_CH_i == C_CH_W'(c));

    subreg_tim_div_ch #(
      .C_PERIOD_W (C_PERIOD_W)
    ) u_ch (
      .CK_i    (CK_i),
      .XARST_i (XARST_i),
      .wr      (wr_c),
      .wr_sel  (WR_SEL_i),
      .wr_dat  (WR_DAT_i),
      .run     (RUN_i[c]),
      .sync    (SYNC_i),
      .en_ck   (EN_CK_o[c]),
      .wrap    (WRAP_o[c]),
      .pend    (PEND_o[c])
    );
  end

endmodule

// File: tb/tb_subreg_tim_div_mc.sv
// Scoreboard bench for subreg_tim_div_mc: reference model pushes expected
// per-cycle outputs, an independent monitor pops and compares them.
module tb_subreg_tim_div_mc;

  localparam int NCH = 3;
  localparam int W   = 8;
  localparam int CHW = 2;

  logic           CK_i     = 1'b0;
  logic           XARST_i  = 1'b0;
  logic           WR_i     = 1'b0;
  logic [CHW-1:0] WR_CH_i  = '0;
  logic           WR_SEL_i = 1'b0;
  logic [W-1:0]   WR_DAT_i = '0;
  logic [NCH-1:0] RUN_i    = '0;
  logic           SYNC_i   = 1'b0;
  logic [NCH-1:0] EN_CK_o, WRAP_o, PEND_o;

  always #5 CK_i = ~CK_i;

  subreg_tim_div_mc #(.C_CH(NCH), .C_PERIOD_W(W)) dut (
    .CK_i     (CK_i),
    .XARST_i  (XARST_i),
    .WR_i     (WR_i),
    .WR_CH_i  (WR_CH_i),
    .WR_SEL_i (WR_SEL_i),
    .WR_DAT_i (WR_DAT_i),
    .RUN_i    (RUN_i),
    .SYNC_i   (SYNC_i),
    .EN_CK_o  (EN_CK_o),
    .WRAP_o   (WRAP_o),
    .PEND_o   (PEND_o)
  );

  typedef struct packed {
    logic [NCH-1:0] en;
    logic [NCH-1:0] wrap;
    logic [NCH-1:0] pend;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, cyc_n = 0;
  logic           rst_v = 1'b0;
  logic [NCH-1:0] run_v = '0;

  // Reference model: pulse placement is a closed form, not an accumulator.
  // Pulses before phase p: E(p) = ceil((p-1)*N/P); a pulse fires at p when
  // E(p+1) > E(p). N == P is "all cycles but the first since restart".
  int m_per_s[NCH], m_pn_s[NCH], m_per_a[NCH], m_pn_a[NCH], m_ph[NCH];
  bit m_pend[NCH], m_fresh[NCH];

  function automatic longint cdiv(input longint a, input longint b);
    return (a + b - 1) / b;
  endfunction

  task automatic model_cycle();
    exp_t e;
    e = '0;
    if (!XARST_i) begin
      for (int c = 0; c < NCH; c++) begin
        m_per_s[c] = 0; m_pn_s[c] = 0; m_per_a[c] = 0; m_pn_a[c] = 0;
        m_ph[c] = 0; m_pend[c] = 0; m_fresh[c] = 1;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        bit act, wrp, en, wr_c, cmt;
        int n;
        act = RUN_i[c] && (m_per_a[c] != 0);
        n   = (m_pn_a[c] < m_per_a[c]) ? m_pn_a[c] : m_per_a[c];
        wrp = act && (m_ph[c] == m_per_a[c] - 1);
        if (!act) en = 0;
        else if (n == m_per_a[c]) en = !m_fresh[c];
        else en = (m_ph[c] > 0) &&
                  (cdiv(longint'(m_ph[c]) * n, m_per_a[c]) >
                   cdiv(longint'(m_ph[c] - 1) * n, m_per_a[c]));
        e.en[c] = en; e.wrap[c] = wrp; e.pend[c] = m_pend[c];
        wr_c = WR_i && (int'(WR_CH_i) == c);
        if (wr_c) begin
          if (WR_SEL_i) m_pn_s[c] = int'(WR_DAT_i);
          else          m_per_s[c] = int'(WR_DAT_i);
        end
        cmt = SYNC_i || !act || (wrp && m_pend[c]);
        if (cmt) begin
          m_per_a[c] = m_per_s[c]; m_pn_a[c] = m_pn_s[c];
          m_ph[c] = 0; m_pend[c] = 0; m_fresh[c] = 1;
        end else begin
          m_ph[c] = wrp ? 0 : m_ph[c] + 1;
          m_fresh[c] = 0;
          if (wr_c) m_pend[c] = 1;
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic cyc(input bit w = 0, input int ch = 0, input bit sel = 0,
                     input int dat = 0, input bit sy = 0);
    @(negedge CK_i);
    XARST_i  = rst_v;
    RUN_i    = run_v;
    WR_i     = w;
    WR_CH_i  = CHW'(ch);
    WR_SEL_i = sel;
    WR_DAT_i = W'(dat);
    SYNC_i   = sy;
    model_cycle();
    cyc_n++;
  endtask

  task automatic wr(input int ch, input bit sel, input int dat);
    cyc(1, ch, sel, dat, 0);
  endtask

  task automatic wait_ph0(input int p);
    int k;
    k = 0;
    while (m_ph[0] != p && k < 300) begin
      cyc();
      k++;
    end
    if (m_ph[0] != p) begin
      checks++; errors++;
      $display("FAIL wait_ph0: phase %0d not reached, at %0d want %0d", p, m_ph[0], p);
    end
  endtask

  // Monitor: outputs are sampled 2 time units after the input update.
  always @(negedge CK_i) begin
    #2;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({EN_CK_o, WRAP_o, PEND_o} !== e) begin
        errors++;
        $display("FAIL outputs @t=%0t en/wrap/pend got %b/%b/%b want %b/%b/%b",
                 $time, EN_CK_o, WRAP_o, PEND_o, e.en, e.wrap, e.pend);
      end
    end
  end

  initial begin
    rst_v = 1'b0; run_v = '0;
    repeat (3) cyc();
    rst_v = 1'b1; cyc();

    // ch0 7/3 and ch1 3/2, plus a write to a non-existent channel
    wr(0, 0, 7); wr(0, 1, 3); wr(1, 0, 3); wr(1, 1, 2);
    wr(3, 0, 5);
    run_v = 3'b011; repeat (21) cyc();

    // Mid-period reconfiguration, saturation and zero pulses
    repeat (2) cyc(); wr(0, 1, 5); repeat (20) cyc();
    wr(0, 1, 9); repeat (16) cyc();
    wr(0, 1, 0); repeat (16) cyc();
    wr(0, 1, 3); wr(2, 0, 5); wr(2, 1, 2);
    run_v = 3'b111; repeat (10) cyc();

    // Global sync at phase 4, then sync coincident with a write
    wait_ph0(4); cyc(0, 0, 0, 0, 1); repeat (12) cyc();
    cyc(1, 1, 0, 4, 1); repeat (12) cyc();

    // Run drop/restore and PERIOD -> 0 while running
    run_v[1] = 1'b0; repeat (3) cyc();
    run_v[1] = 1'b1; repeat (10) cyc();
    wr(2, 0, 0); repeat (12) cyc();

    // Asynchronous reset mid-operation
    wait_ph0(3); rst_v = 1'b0; repeat (2) cyc();
    rst_v = 1'b1; repeat (10) cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) run_v = NCH'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        int d;
        d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 12));
        cyc(1, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), d,
            $urandom_range(0, 49) == 0);
      end else begin
        cyc(0, 0, 0, 0, $urandom_range(0, 49) == 0);
      end
    end

    @(negedge CK_i); #5;
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
